// File: rtl/servo_pkg.sv
// Shared command encoding and command-to-pulse-width decode for the servo PWM array.
package servo_pkg;

  typedef enum logic [1:0] {
    CMD_STOP0 = 2'b00,
    CMD_FWD   = 2'b01,
    CMD_BACK  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_t;

  function automatic int unsigned cmd_to_width(input cmd_t cmd,
                                               input int unsigned t_back,
                                               input int unsigned t_stop,
                                               input int unsigned t_fwd);
    int unsigned w;
    case (cmd)
      CMD_FWD:  w = t_fwd;
      CMD_BACK: w = t_back;
      default:  w = t_stop;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: frame-boundary command capture, optional slew limiting of the
// pulse width, and the registered pulse compare against the shared frame counter.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned T_BACK    = 154,
  parameter int unsigned T_STOP    = 230,
  parameter int unsigned T_FWD     = 307,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_end_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [1:0]       instr_i,
  input  logic             en_i,
  input  logic             ramp_en_i,
  output logic             pwm_o,
  output logic             settled_o
);

  localparam logic [CNT_W-1:0]        STOP_W = CNT_W'(T_STOP);
  localparam logic [CNT_W-1:0]        STEP_W = CNT_W'(RAMP_STEP);
  localparam logic signed [CNT_W:0]   STEP_S = $signed((CNT_W+1)'(RAMP_STEP));

  logic [CNT_W-1:0]      tgt_q, tgt_d, cur_q, cur_d, tgt_new_s;
  logic                  en_q, en_d, pwm_q, pwm_d;
  logic signed [CNT_W:0] diff_s;

  // Next-state: widths and enable only move at the frame boundary.
  always_comb begin
    tgt_new_s = CNT_W'(cmd_to_width(cmd_t'(instr_i), T_BACK, T_STOP, T_FWD));
    diff_s    = $signed({1'b0, tgt_new_s}) - $signed({1'b0, cur_q});
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    en_d      = en_q;
    if (frame_end_i) begin
      tgt_d = tgt_new_s;
      en_d  = en_i;
      if (!en_i) begin
        cur_d = STOP_W;
      end else if (!ramp_en_i || RAMP_STEP == 32'd0) begin
        cur_d = tgt_new_s;
      end else if (diff_s > STEP_S) begin
        cur_d = cur_q + STEP_W;
      end else if (diff_s < -STEP_S) begin
        cur_d = cur_q - STEP_W;
      end else begin
        cur_d = tgt_new_s;
      end
    end else begin
      cur_d = cur_q;
    end
    // Compare uses the pre-edge count, so the pulse covers counts 1..cur_w.
    pwm_d = en_q && (count_i < cur_q);
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q <= STOP_W;
      cur_q <= STOP_W;
      en_q  <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      en_q  <= en_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign settled_o = (cur_q == tgt_q);

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator: one shared frame counter driving NCH
// independently commanded, optionally slew-limited pulse channels.
module servo_pwm_array
  import servo_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned PERIOD    = 3072,
  parameter int unsigned T_BACK    = 154,
  parameter int unsigned T_STOP    = 230,
  parameter int unsigned T_FWD     = 307,
  parameter int unsigned RAMP_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2*NCH-1:0] instr,
  input  logic [NCH-1:0]   en,
  input  logic             ramp_en,
  output logic [NCH-1:0]   pwm,
  output logic [NCH-1:0]   settled,
  output logic             frame_tick
);

  localparam int unsigned      CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 32'd1);

  if (!(T_BACK > 32'd0 && T_BACK <= T_STOP && T_STOP <= T_FWD && T_FWD < PERIOD && NCH >= 32'd1))
  begin : g_bad_params
    $error("servo_pwm_array: illegal parameter set");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             frame_end_s;

  // Free-running frame counter.
  always_comb begin
    frame_end_s = (count_q == LAST);
    if (frame_end_s) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign frame_tick = (count_q == {CNT_W{1'b0}});

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    servo_channel #(
      .CNT_W     (CNT_W),
      .T_BACK    (T_BACK),
      .T_STOP    (T_STOP),
      .T_FWD     (T_FWD),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .frame_end_i (frame_end_s),
      .count_i     (count_q),
      .instr_i     (instr[2*i+1:2*i]),
      .en_i        (en[i]),
      .ramp_en_i   (ramp_en),
      .pwm_o       (pwm[i]),
      .settled_o   (settled[i])
    );
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Scoreboard bench: stimulus queues the expected per-frame widths/settled,
// a monitor measures each completed frame and compares.
module tb_servo_pwm_array;

  localparam int PERIOD = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] instr;
  logic [1:0] en;
  logic       ramp_en;
  logic [1:0] pwm, settled;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         w0;
    int         w1;
    logic [1:0] s;
  } exp_t;

  typedef struct {
    logic [3:0] instr;
    logic [1:0] en;
    logic       ramp;
    int         w0;
    int         w1;
    logic [1:0] s;
  } vec_t;

  exp_t exp_q[$];

  servo_pwm_array #(
    .NCH(2), .PERIOD(PERIOD), .T_BACK(10), .T_STOP(15), .T_FWD(20), .RAMP_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .instr(instr), .en(en), .ramp_en(ramp_en),
    .pwm(pwm), .settled(settled), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: measure each frame delimited by frame_tick, compare with scoreboard.
  int   idx = 0;
  bit   in_frame = 1'b0;
  int   hi[2];
  bit   shape_ok[2];
  logic [1:0] set_smp;
  int   frame_no = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else if (frame_tick) begin
      if (in_frame) begin
        exp_t e;
        chk("frame_len", idx + 1, PERIOD);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", frame_no, -1);
        end else begin
          e = exp_q.pop_front();
          chk("width_ch0", hi[0], e.w0);
          chk("width_ch1", hi[1], e.w1);
          chk("shape_ch0", int'(shape_ok[0]), 1);
          chk("shape_ch1", int'(shape_ok[1]), 1);
          chk("settled", int'(set_smp), int'(e.s));
        end
        frame_no++;
      end
      in_frame = 1'b1;
      idx = 0;
      for (int i = 0; i < 2; i++) begin
        hi[i] = 0;
        shape_ok[i] = !pwm[i];
      end
    end else if (in_frame) begin
      idx++;
      for (int i = 0; i < 2; i++) begin
        if (pwm[i]) begin
          if (idx != hi[i] + 1) shape_ok[i] = 1'b0;
          hi[i]++;
        end
      end
      if (idx == 100) set_smp = settled;
    end
  end

  task automatic wait_tick();
    for (int n = 0; n < 2 * PERIOD; n++) begin
      @(negedge clk);
      if (frame_tick && !reset) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{4'b1111, 2'b11, 1'b0, 15, 15, 2'b11};
    vecs[1]  = '{4'b1101, 2'b11, 1'b0, 20, 15, 2'b11};
    vecs[2]  = '{4'b1111, 2'b11, 1'b0, 15, 15, 2'b11};
    vecs[3]  = '{4'b1110, 2'b11, 1'b1, 13, 15, 2'b10};
    vecs[4]  = '{4'b1110, 2'b11, 1'b1, 11, 15, 2'b10};
    vecs[5]  = '{4'b1110, 2'b11, 1'b1, 10, 15, 2'b11};
    vecs[6]  = '{4'b1110, 2'b11, 1'b1, 10, 15, 2'b11};
    vecs[7]  = '{4'b0110, 2'b01, 1'b1, 10,  0, 2'b01};
    vecs[8]  = '{4'b0110, 2'b11, 1'b1, 10, 17, 2'b01};
    vecs[9]  = '{4'b0110, 2'b11, 1'b1, 10, 19, 2'b01};
    vecs[10] = '{4'b0110, 2'b11, 1'b1, 10, 20, 2'b11};
    vecs[11] = '{4'b0010, 2'b11, 1'b0, 10, 15, 2'b11};
    vecs[12] = '{4'b0001, 2'b11, 1'b1, 12, 15, 2'b10};
    vecs[13] = '{4'b0001, 2'b11, 1'b0, 20, 15, 2'b11};

    reset = 1'b1; instr = 4'b0000; en = 2'b00; ramp_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_tick", int'(frame_tick), 1);
    chk("rst_settled", int'(settled), 3);
    exp_q.push_back('{0, 0, 2'b11});
    @(posedge clk); #1 reset = 1'b0;

    foreach (vecs[k]) begin
      wait_tick();
      repeat (5) @(negedge clk);
      instr = vecs[k].instr; en = vecs[k].en; ramp_en = vecs[k].ramp;
      exp_q.push_back('{vecs[k].w0, vecs[k].w1, vecs[k].s});
    end
    wait_tick();
    wait_tick();

    // Reset at count 7 while both pulses are high.
    repeat (7) @(negedge clk);
    chk("pre_reset_pwm", int'(pwm), 3);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pwm", int'(pwm), 0);
    chk("midrst_tick", int'(frame_tick), 1);
    chk("midrst_settled", int'(settled), 3);
    exp_q.push_back('{0, 0, 2'b11});
    @(posedge clk); #1 reset = 1'b0;
    chk("post_rst_tick", int'(frame_tick), 1);

    wait_tick();
    repeat (5) @(negedge clk);
    instr = 4'b0011; en = 2'b11; ramp_en = 1'b1;
    exp_q.push_back('{15, 15, 2'b11});
    wait_tick();
    wait_tick();
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
